// File: rtl/sys_bridge.sv
// Bridge from the CPU data port to N_DEV memory-mapped devices: window decode, req/ack
// handshake with timeout, and an edge-latched, maskable interrupt block behind control registers.
//
// state | meaning
// IDLE  | waiting for pr_req; decodes and captures the access
// DEV   | one device selected, waiting for its ack or the timeout
// CTRL  | bridge-local register read or write
// DONE  | one-cycle pr_ready with latched rd/err
module sys_bridge #(
    parameter int               N_DEV        = 6,
    parameter logic [31:0]      DEV_BASE     = 32'h0000_7f00,
    parameter logic [31:0]      DEV_SPAN     = 32'h10,
    parameter logic [31:0]      DEV_BYTES    = 32'd12,
    parameter logic [31:0]      CTRL_BASE    = 32'h0000_7f80,
    parameter int               TIMEOUT      = 64,
    parameter logic [N_DEV-1:0] INT_MASK_RST = '1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pr_req,
    input  logic [31:0]         pr_addr,
    input  logic                pr_we,
    input  logic [3:0]          pr_be,
    input  logic [31:0]         pr_wd,
    output logic [31:0]         pr_rd,
    output logic                pr_ready,
    output logic                pr_err,
    output logic [N_DEV-1:0]    pr_int,
    output logic [29:0]         dev_addr,
    output logic [31:0]         dev_wd,
    output logic [3:0]          dev_be,
    output logic                dev_we,
    output logic [N_DEV-1:0]    dev_sel,
    input  logic [N_DEV*32-1:0] dev_rd,
    input  logic [N_DEV-1:0]    dev_ack,
    input  logic [N_DEV-1:0]    dev_int
);
    typedef enum logic [1:0] {IDLE, DEV, CTRL, DONE} bridgeState;
    localparam int CW = $clog2(TIMEOUT + 1);

    bridgeState       state;
    logic [CW-1:0]    waitCnt;
    logic             capWe;
    logic [N_DEV-1:0] intMask, intPend, devIntQ, hitDev, pendClr;
    logic [29:0]      statusAddr;
    logic             statusErr;
    logic             hitCtrl, badAddr, ackSel;
    logic [31:0]      rdSel, ctrlRd;
    logic [1:0]       ctrlOff;

    always_comb begin
        hitDev = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (pr_addr >= DEV_BASE + 32'(i) * DEV_SPAN &&
                pr_addr <= DEV_BASE + 32'(i) * DEV_SPAN + DEV_BYTES - 32'd1)
                hitDev[i] = 1'b1;
        end
    end

    assign hitCtrl = (pr_addr >= CTRL_BASE) && (pr_addr <= CTRL_BASE + 32'd11);
    assign badAddr = (|pr_addr[1:0]) || (hitDev == '0 && !hitCtrl);
    assign ackSel  = |(dev_sel & dev_ack);

    always_comb begin
        rdSel = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (dev_sel[i])
                rdSel = rdSel | dev_rd[32*i +: 32];
        end
    end

    // The control block spans only three words, so the low two word-address bits identify the register.
    assign ctrlOff = dev_addr[1:0] - CTRL_BASE[3:2];

    always_comb begin
        ctrlRd = '0;
        case (ctrlOff)
            2'd0:    ctrlRd = 32'(intMask);
            2'd1:    ctrlRd = 32'(intPend);
            2'd2:    ctrlRd = {statusErr, 1'b0, statusAddr};
            default: ctrlRd = '0;
        endcase
    end

    assign pendClr = (state == CTRL && capWe && ctrlOff == 2'd1) ? dev_wd[N_DEV-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            capWe      <= 1'b0;
            pr_rd      <= '0;
            pr_ready   <= 1'b0;
            pr_err     <= 1'b0;
            pr_int     <= '0;
            dev_addr   <= '0;
            dev_wd     <= '0;
            dev_be     <= '0;
            dev_we     <= 1'b0;
            dev_sel    <= '0;
            intMask    <= INT_MASK_RST;
            intPend    <= '0;
            devIntQ    <= '0;
            statusAddr <= '0;
            statusErr  <= 1'b0;
        end else begin
            devIntQ  <= dev_int;
            // A new rising edge wins over a simultaneous write-1-to-clear.
            intPend  <= (intPend & ~pendClr) | (dev_int & ~devIntQ);
            pr_int   <= intPend & intMask;
            pr_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (pr_req) begin
                        dev_addr <= pr_addr[31:2];
                        dev_wd   <= pr_wd;
                        dev_be   <= pr_be;
                        capWe    <= pr_we;
                        pr_rd    <= '0;
                        if (badAddr) begin
                            state      <= DONE;
                            pr_ready   <= 1'b1;
                            pr_err     <= 1'b1;
                            statusAddr <= pr_addr[31:2];
                            statusErr  <= 1'b1;
                        end else if (hitDev != '0) begin
                            state   <= DEV;
                            dev_sel <= hitDev;
                            dev_we  <= pr_we;
                            waitCnt <= CW'(TIMEOUT);
                        end else begin
                            state <= CTRL;
                        end
                    end
                end
                DEV: begin
                    if (ackSel) begin
                        state    <= DONE;
                        pr_ready <= 1'b1;
                        pr_err   <= 1'b0;
                        pr_rd    <= rdSel;
                        dev_sel  <= '0;
                        dev_we   <= 1'b0;
                    end else if (waitCnt == '0) begin
                        state      <= DONE;
                        pr_ready   <= 1'b1;
                        pr_err     <= 1'b1;
                        pr_rd      <= '0;
                        dev_sel    <= '0;
                        dev_we     <= 1'b0;
                        statusAddr <= dev_addr;
                        statusErr  <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                CTRL: begin
                    state    <= DONE;
                    pr_ready <= 1'b1;
                    pr_err   <= 1'b0;
                    if (!capWe) begin
                        pr_rd <= ctrlRd;
                    end else if (ctrlOff == 2'd0) begin
                        intMask <= dev_wd[N_DEV-1:0];
                    end else if (ctrlOff == 2'd2) begin
                        statusErr <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    pr_err <= 1'b0;
                    pr_rd  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_bridge.sv
// Randomised bench for sys_bridge: a transaction-level model of the address map, control
// registers and handshake latencies predicts every response.
module tb_sys_bridge;
    localparam int          N_DEV     = 6;
    localparam logic [31:0] DEV_BASE  = 32'h0000_7f00;
    localparam logic [31:0] DEV_SPAN  = 32'h10;
    localparam logic [31:0] DEV_BYTES = 32'd12;
    localparam logic [31:0] CTRL_BASE = 32'h0000_7f80;
    localparam int          TIMEOUT   = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                pr_req, pr_we, pr_ready, pr_err;
    logic [31:0]         pr_addr, pr_wd, pr_rd;
    logic [3:0]          pr_be, dev_be;
    logic [N_DEV-1:0]    pr_int, dev_sel, dev_ack, dev_int;
    logic [29:0]         dev_addr;
    logic [31:0]         dev_wd;
    logic                dev_we;
    logic [N_DEV*32-1:0] dev_rd;

    int vectors = 0;
    int miscompares = 0;

    logic [N_DEV-1:0] mMask, mPend;
    logic [29:0]      mStatAddr;
    logic             mStatFlag;
    logic [31:0]      devRdVal [N_DEV];

    sys_bridge #(.N_DEV(N_DEV), .DEV_BASE(DEV_BASE), .DEV_SPAN(DEV_SPAN), .DEV_BYTES(DEV_BYTES),
                 .CTRL_BASE(CTRL_BASE), .TIMEOUT(TIMEOUT), .INT_MASK_RST('1)) dut (
        .clk(clk), .reset(reset), .pr_req(pr_req), .pr_addr(pr_addr), .pr_we(pr_we),
        .pr_be(pr_be), .pr_wd(pr_wd), .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
        .pr_int(pr_int), .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_be(dev_be),
        .dev_we(dev_we), .dev_sel(dev_sel), .dev_rd(dev_rd), .dev_ack(dev_ack), .dev_int(dev_int)
    );

    always #5 clk = ~clk;

    task automatic setDevRd();
        for (int i = 0; i < N_DEV; i++) dev_rd[32*i +: 32] = devRdVal[i];
    endtask

    // Predicts one access from the address map and the control-register rules; ackDelay 0 = never acks.
    task automatic modelAccess(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                               input int ackDelay, output int eDev, output logic [31:0] eRd,
                               output logic eErr, output int eLat);
        logic       ctrl;
        logic [31:0] off;
        eDev = -1; eRd = '0; eErr = 1'b0; eLat = 0;
        for (int i = 0; i < N_DEV; i++)
            if (addr >= DEV_BASE + 32'(i) * DEV_SPAN && addr < DEV_BASE + 32'(i) * DEV_SPAN + DEV_BYTES)
                eDev = i;
        ctrl = (addr >= CTRL_BASE) && (addr < CTRL_BASE + 32'd12);
        if (addr[1:0] != 2'b00 || (eDev < 0 && !ctrl)) begin
            eDev = -1; eErr = 1'b1; eLat = 1;
            mStatAddr = addr[31:2]; mStatFlag = 1'b1;
        end else if (eDev >= 0) begin
            if (ackDelay == 0) begin
                eErr = 1'b1; eLat = TIMEOUT + 2;
                mStatAddr = addr[31:2]; mStatFlag = 1'b1;
            end else begin
                eLat = ackDelay + 1; eRd = devRdVal[eDev];
            end
        end else begin
            eLat = 2;
            off = (addr - CTRL_BASE) >> 2;
            if (!we) begin
                if (off == 0) eRd = 32'(mMask);
                else if (off == 1) eRd = 32'(mPend);
                else eRd = {mStatFlag, 1'b0, mStatAddr};
            end else begin
                if (off == 0) mMask = wd[N_DEV-1:0];
                else if (off == 1) mPend = mPend & ~wd[N_DEV-1:0];
                else mStatFlag = 1'b0;
            end
        end
    endtask

    // Runs one CPU access, acting as device ackDev (acks in its ackDelay-th select cycle) and
    // driving random acks on every other device. lat counts edges from request drive to pr_ready.
    task automatic doAccess(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input int ackDev, input int ackDelay,
                            input logic [N_DEV-1:0] intPulse, input int intAt,
                            output logic [31:0] rd, output logic err, output int lat,
                            output int sc, output logic sideOk, output logic tail);
        logic             done;
        logic [N_DEV-1:0] ackVec;
        @(negedge clk);
        pr_req = 1'b1; pr_addr = addr; pr_we = we; pr_be = be; pr_wd = wd;
        lat = 0; sc = 0; sideOk = 1'b1; done = 1'b0; rd = 'x; err = 1'bx; tail = 1'bx;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == intAt) dev_int = dev_int | intPulse;
            if (dev_sel != '0) begin
                sc++;
                if (ackDev < 0 || dev_sel !== (N_DEV'(1) << ackDev) || dev_we !== we ||
                    dev_addr !== addr[31:2] || dev_wd !== wd || dev_be !== be)
                    sideOk = 1'b0;
            end else if (dev_we !== 1'b0) begin
                sideOk = 1'b0;
            end
            ackVec = N_DEV'($urandom);
            if (ackDev >= 0)
                ackVec[ackDev] = dev_sel[ackDev] && ackDelay != 0 && sc == ackDelay;
            dev_ack = ackVec;
            if (pr_ready === 1'b1) begin
                done = 1'b1; rd = pr_rd; err = pr_err;
            end
        end
        pr_req = 1'b0; dev_ack = '0;
        @(negedge clk);
        tail = pr_ready;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err, sideOk, tail; int lat, sc;
        vectors++; if (pr_ready !== 1'b0 || pr_err !== 1'b0) begin miscompares++;
            $display("FAIL reset ready/err: got %b%b want 00", pr_ready, pr_err); end
        vectors++; if (pr_rd !== 32'h0 || pr_int !== '0) begin miscompares++;
            $display("FAIL reset rd/int: got %h/%b want 0/0", pr_rd, pr_int); end
        vectors++; if (dev_sel !== '0 || dev_we !== 1'b0) begin miscompares++;
            $display("FAIL reset sel/we: got %b/%b want 0/0", dev_sel, dev_we); end
        vectors++; if (dev_addr !== '0 || dev_wd !== '0 || dev_be !== '0) begin miscompares++;
            $display("FAIL reset devbus: got %h %h %h want 0", dev_addr, dev_wd, dev_be); end
        @(negedge clk); reset = 1'b0;
        mMask = '1; mPend = '0; mStatAddr = '0; mStatFlag = 1'b0;
        doAccess(CTRL_BASE, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (rd !== 32'h3f || lat != 2) begin miscompares++;
            $display("FAIL reset mask: got %h lat %0d want 3f lat 2", rd, lat); end
        doAccess(CTRL_BASE + 4, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (rd !== 32'h0) begin miscompares++;
            $display("FAIL reset pend: got %h want 0", rd); end
        doAccess(CTRL_BASE + 8, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (rd !== 32'h0 || err !== 1'b0) begin miscompares++;
            $display("FAIL reset status: got %h err %b want 0", rd, err); end
    endtask

    task automatic test_dev_read();
        logic [31:0] rd, eRd; logic err, sideOk, tail, eErr; int lat, sc, eDev, eLat;
        for (int i = 0; i < N_DEV; i++) devRdVal[i] = $urandom;
        devRdVal[1] = 32'hDEADBEEF; setDevRd();
        modelAccess(32'h7f14, 1'b0, '0, 3, eDev, eRd, eErr, eLat);
        doAccess(32'h7f14, 1'b0, 4'hF, '0, 1, 3, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (sc != 3 || !sideOk) begin miscompares++;
            $display("FAIL devRead sel: got %0d cycles ok=%b want 3 ok=1", sc, sideOk); end
        vectors++; if (lat != 4 || tail !== 1'b0) begin miscompares++;
            $display("FAIL devRead latency: got %0d tail %b want 4 tail 0", lat, tail); end
        vectors++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin miscompares++;
            $display("FAIL devRead data: got %h err %b want deadbeef err 0", rd, err); end
    endtask

    task automatic test_dev_write();
        logic [31:0] rd, eRd, wd; logic err, sideOk, tail, eErr; int lat, sc, eDev, eLat;
        wd = $urandom;
        modelAccess(32'h7f08, 1'b1, wd, 1, eDev, eRd, eErr, eLat);
        doAccess(32'h7f08, 1'b1, 4'hF, wd, 0, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (sc != 1 || !sideOk) begin miscompares++;
            $display("FAIL devWrite strobe: got %0d cycles ok=%b want 1 ok=1", sc, sideOk); end
        vectors++; if (lat != 2 || err !== 1'b0) begin miscompares++;
            $display("FAIL devWrite latency: got %0d err %b want 2 err 0", lat, err); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, eRd; logic err, sideOk, tail, eErr; int lat, sc, eDev, eLat;
        logic [31:0] addrs [2];
        logic [31:0] stat [2];
        addrs[0] = 32'h7f0c; addrs[1] = 32'h7f02;
        stat[0] = 32'h8000_1fc3; stat[1] = 32'h8000_1fc0;
        for (int k = 0; k < 2; k++) begin
            modelAccess(addrs[k], 1'b0, '0, 1, eDev, eRd, eErr, eLat);
            doAccess(addrs[k], 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
            vectors++; if (lat != 1 || err !== 1'b1 || rd !== 32'h0 || !sideOk) begin miscompares++;
                $display("FAIL unmapped %h: got lat %0d err %b rd %h ok %b want 1 1 0 1", addrs[k], lat, err, rd, sideOk); end
            modelAccess(CTRL_BASE + 8, 1'b0, '0, 1, eDev, eRd, eErr, eLat);
            doAccess(CTRL_BASE + 8, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
            vectors++; if (rd !== stat[k]) begin miscompares++;
                $display("FAIL unmapped status: got %h want %h", rd, stat[k]); end
        end
        modelAccess(CTRL_BASE + 8, 1'b1, '0, 1, eDev, eRd, eErr, eLat);
        doAccess(CTRL_BASE + 8, 1'b1, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        modelAccess(CTRL_BASE + 8, 1'b0, '0, 1, eDev, eRd, eErr, eLat);
        doAccess(CTRL_BASE + 8, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (rd !== 32'h0000_1fc0) begin miscompares++;
            $display("FAIL status clear: got %h want 00001fc0", rd); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd, eRd; logic err, sideOk, tail, eErr; int lat, sc, eDev, eLat;
        modelAccess(32'h7f20, 1'b0, '0, 0, eDev, eRd, eErr, eLat);
        doAccess(32'h7f20, 1'b0, 4'hF, '0, 2, 0, '0, 0, rd, err, lat, sc, sideOk, tail);
        // Accepted at the first edge, so ready at T0+TIMEOUT+1 is TIMEOUT+2 edges after the drive.
        vectors++; if (lat != TIMEOUT + 2 || err !== 1'b1 || rd !== 32'h0) begin miscompares++;
            $display("FAIL timeout: got lat %0d err %b rd %h want %0d 1 0", lat, err, rd, TIMEOUT + 2); end
        vectors++; if (sc != TIMEOUT + 1 || !sideOk || tail !== 1'b0) begin miscompares++;
            $display("FAIL timeout sel: got %0d ok %b tail %b want %0d 1 0", sc, sideOk, tail, TIMEOUT + 1); end
        devRdVal[2] = $urandom; setDevRd();
        modelAccess(32'h7f28, 1'b0, '0, 2, eDev, eRd, eErr, eLat);
        doAccess(32'h7f28, 1'b0, 4'hF, '0, 2, 2, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (lat != 3 || err !== 1'b0 || rd !== devRdVal[2]) begin miscompares++;
            $display("FAIL afterTimeout: got lat %0d err %b rd %h want 3 0 %h", lat, err, rd, devRdVal[2]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, eRd, addr, wd; logic err, sideOk, tail, eErr, we; int lat, sc, eDev, eLat, delay, kind;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N_DEV; i++) devRdVal[i] = $urandom;
            setDevRd();
            kind = $urandom_range(0, 9);
            if (kind <= 5) addr = DEV_BASE + 32'($urandom_range(0, N_DEV - 1)) * DEV_SPAN + 32'($urandom_range(0, 15));
            else if (kind <= 7) addr = CTRL_BASE + 32'($urandom_range(0, 15));
            else if (kind == 8) addr = $urandom;
            else addr = ($urandom_range(0, 1) == 0) ? DEV_BASE - 32'd4 : DEV_BASE + 32'(N_DEV) * DEV_SPAN;
            we = 1'($urandom); wd = $urandom;
            delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            modelAccess(addr, we, wd, delay, eDev, eRd, eErr, eLat);
            doAccess(addr, we, 4'($urandom), wd, eDev, delay, '0, 0, rd, err, lat, sc, sideOk, tail);
            vectors++; if (err !== eErr || lat != eLat) begin miscompares++;
                $display("FAIL random %h: got err %b lat %0d want err %b lat %0d", addr, err, lat, eErr, eLat); end
            vectors++; if (!sideOk || tail !== 1'b0) begin miscompares++;
                $display("FAIL random bus %h: got ok %b tail %b want 1 0", addr, sideOk, tail); end
            if (!we) begin
                vectors++; if (rd !== eRd) begin miscompares++;
                    $display("FAIL random rd %h: got %h want %h", addr, rd, eRd); end
            end
            if (eDev >= 0) begin
                vectors++; if (sc != (eErr ? TIMEOUT + 1 : delay)) begin miscompares++;
                    $display("FAIL random selCycles %h: got %0d want %0d", addr, sc, eErr ? TIMEOUT + 1 : delay); end
            end
        end
    endtask

    task automatic test_interrupts();
        logic [31:0] rd; logic err, sideOk, tail; int lat, sc;
        logic [N_DEV-1:0] m, r;
        doAccess(CTRL_BASE, 1'b1, 4'hF, 32'h3f, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        @(negedge clk); dev_int = 6'b001000;
        @(negedge clk);
        vectors++; if (pr_int !== 6'b000000) begin miscompares++;
            $display("FAIL int early: got %b want 000000", pr_int); end
        @(negedge clk);
        vectors++; if (pr_int !== 6'b001000) begin miscompares++;
            $display("FAIL int rise: got %b want 001000", pr_int); end
        dev_int = '0;
        // W1C of bit 3 coincides with a fresh rising edge on bit 3.
        doAccess(CTRL_BASE + 4, 1'b1, 4'hF, 32'h08, -1, 1, 6'b001000, 1, rd, err, lat, sc, sideOk, tail);
        doAccess(CTRL_BASE + 4, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (rd !== 32'h08) begin miscompares++;
            $display("FAIL int setWins: got %h want 00000008", rd); end
        doAccess(CTRL_BASE + 4, 1'b1, 4'hF, 32'h08, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (pr_int !== '0) begin miscompares++;
            $display("FAIL int w1c prInt: got %b want 000000", pr_int); end
        doAccess(CTRL_BASE + 4, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (rd !== 32'h0) begin miscompares++;
            $display("FAIL int w1c pend: got %h want 0", rd); end
        dev_int = '0; @(negedge clk); dev_int = 6'b001000; repeat (2) @(negedge clk);
        doAccess(CTRL_BASE, 1'b1, 4'hF, 32'h0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (pr_int !== '0) begin miscompares++;
            $display("FAIL int masked: got %b want 000000", pr_int); end
        doAccess(CTRL_BASE + 4, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (rd !== 32'h08) begin miscompares++;
            $display("FAIL int masked pend: got %h want 00000008", rd); end
        for (int n = 0; n < 5; n++) begin
            m = N_DEV'($urandom); r = N_DEV'($urandom);
            dev_int = '0;
            doAccess(CTRL_BASE, 1'b1, 4'hF, 32'(m), -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
            doAccess(CTRL_BASE + 4, 1'b1, 4'hF, 32'h3f, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
            @(negedge clk); dev_int = r;
            repeat (3) @(negedge clk);
            vectors++; if (pr_int !== (r & m)) begin miscompares++;
                $display("FAIL int random: got %b want %b", pr_int, r & m); end
        end
        dev_int = '0;
    endtask

    task automatic test_reset_inflight();
        logic [31:0] rd; logic err, sideOk, tail; int lat, sc; int seen;
        doAccess(CTRL_BASE, 1'b1, 4'hF, 32'h3f, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        doAccess(CTRL_BASE + 4, 1'b1, 4'hF, 32'h3f, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        @(negedge clk); dev_int = 6'b000001;
        repeat (2) @(negedge clk); dev_int = '0;
        pr_req = 1'b1; pr_addr = 32'h7f20; pr_we = 1'b0; pr_be = 4'hF; pr_wd = '0;
        repeat (4) @(negedge clk);
        vectors++; if (dev_sel !== 6'b000100 || pr_int !== 6'b000001) begin miscompares++;
            $display("FAIL inflight setup: got sel %b int %b want 000100 000001", dev_sel, pr_int); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (dev_sel !== '0 || pr_ready !== 1'b0 || pr_int !== '0) begin miscompares++;
            $display("FAIL inflight async: got sel %b ready %b int %b want 0 0 0", dev_sel, pr_ready, pr_int); end
        pr_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (80) begin @(negedge clk); if (pr_ready !== 1'b0) seen++; end
        vectors++; if (seen != 0) begin miscompares++;
            $display("FAIL inflight readyAfterReset: got %0d pulses want 0", seen); end
        doAccess(CTRL_BASE + 4, 1'b0, 4'hF, '0, -1, 1, '0, 0, rd, err, lat, sc, sideOk, tail);
        vectors++; if (rd !== 32'h0) begin miscompares++;
            $display("FAIL inflight pend: got %h want 0", rd); end
    endtask

    initial begin
        reset = 1'b1; pr_req = 1'b0; pr_addr = '0; pr_we = 1'b0; pr_be = '0; pr_wd = '0;
        dev_ack = '0; dev_int = '0; dev_rd = '0;
        for (int i = 0; i < N_DEV; i++) devRdVal[i] = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_dev_read();
        test_dev_write();
        test_unmapped();
        test_timeout();
        test_random();
        test_interrupts();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
